vc_allocator_rr: RTL and testbench
==================================

VC_ALLOCATOR_RR -- requirements
Module: vc_allocator_rr

Interface
REQ-001 SHALL have parameter N_OF_REQUEST, default 3: number of requesters.
REQ-002 SHALL have parameter N_OF_VN, default 3: number of virtual networks.
REQ-003 SHALL have parameter N_OF_VC, default 2: number of VCs per VNET.
REQ-004 SHALL have parameter N_BITS_VNET_ID, default clog2(N_OF_VN): width of each VNET id field.
REQ-005 SHALL have parameter ALLOC_MODE, default 1: 0 = fixed priority, lowest index wins; 1 = round-robin.
REQ-006 SHALL have input clk, 1 bit: the single clock.
REQ-007 SHALL have input rst, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have input r_va_i, N_OF_REQUEST bits: level request per requester.
REQ-009 SHALL have input vnet_of_the_request_i, N_OF_REQUEST*N_BITS_VNET_ID bits: VNET id of requester k in field k.
REQ-010 SHALL have input free_signal_i, N_OF_VC*N_OF_VN bits: downstream router VC free.
REQ-011 SHALL have input fifo_pointer_state_i, N_OF_VC*N_OF_VN bits: local FIFO slot available.
REQ-012 SHALL have input release_vc_i, N_OF_VC*N_OF_VN bits: one-cycle pulse that ends the reservation of a VC.
REQ-013 SHALL have output g_va_o, N_OF_REQUEST bits: registered one-cycle grant pulse.
REQ-014 SHALL have output g_vc_id_o, N_OF_REQUEST*N_OF_VC*N_OF_VN bits: registered one-hot granted VC, field k.
REQ-015 SHALL have output reserved_o, N_OF_VC*N_OF_VN bits: current reservation mask.

Function
REQ-016 SHALL index VC j of VNET v as bit v*N_OF_VC+j in all VC vectors.
REQ-017 SHALL compute eligible = free_signal_i & fifo_pointer_state_i & ~reserved.
REQ-018 SHALL treat requester k as active when r_va_i[k]=1, its VNET id < N_OF_VN, and g_va_o[k]=0; an id >= N_OF_VN SHALL never be granted.
REQ-019 SHALL, per VNET per cycle, select at most one active requester (requester arbiter) and at most one eligible VC of that VNET (VC arbiter); no grant for a VNET with zero eligible VCs.
REQ-020 SHALL allow independent VNETs to grant in the same cycle, up to N_OF_VN grants/cycle.
REQ-021 SHALL register the grant: g_va_o[k] and the one-hot g_vc_id_o field k assert in the cycle after the request is evaluated; latency 1 cycle.
REQ-022 SHALL drive g_vc_id_o field k to zero whenever g_va_o[k]=0.
REQ-023 SHALL set reserved[vc] on the clock edge that registers a grant of that VC.
REQ-024 SHALL clear reserved[vc] on the edge where release_vc_i[vc]=1.
REQ-025 SHALL evaluate eligibility from the pre-edge reserved mask when grant and release hit the same VC in one cycle; the VC is then not granted and ends the cycle unreserved.
REQ-026 SHALL, in ALLOC_MODE=1, keep per VNET a requester pointer and a VC pointer; the winner is the first active or eligible index at or above the pointer, wrapping modulo the count.
REQ-027 SHALL, in ALLOC_MODE=1, move both pointers to winner+1 (wrapping) only on a grant.
REQ-028 SHALL, in ALLOC_MODE=0, ignore the pointers and have the lowest index win.
REQ-029 SHALL ignore release_vc_i on unreserved VCs.
REQ-030 SHALL expect requesters to hold r_va_i until g_va_o, then drop it; a request still high while g_va_o[k]=1 SHALL be masked and not re-granted.

Reset
REQ-031 SHALL, on rst=0, immediately clear g_va_o, g_vc_id_o, reserved and reserved_o, and set all pointers to 0.
REQ-032 SHALL hold all state reset while rst=0 and start arbitration on the first edge after rst rises; grants in flight SHALL be discarded.

Verification (N_OF_REQUEST=3, N_OF_VN=3, N_OF_VC=2, ALLOC_MODE=1)
REQ-033 SHALL cover the basic grant: after reset, r_va_i=101, vnet=100101, free=011111, fifo=101101 -> next cycle g_va_o=001, g_vc_id_o field0=000100, reserved_o=000100; req2 gets no grant (VNET2 has no eligible VC).
REQ-034 SHALL cover round-robin: req0 and req1 both on VNET0, all VCs free and unreserved, requests held until granted -> req0 gets 000001, then req1 gets 000010 the following cycle.
REQ-035 SHALL cover exhaustion: VNET1 VCs 2,3 reserved, new VNET1 request -> no grant until release_vc_i=000100; grant of 000100 appears two cycles after the release pulse.
REQ-036 SHALL cover simultaneous grant and release: same-cycle release of reserved bit 2 with a VNET1 request, bit 3 ineligible -> no grant that cycle, reserved[2]=0 after, grant of bit 2 the next cycle.
REQ-037 SHALL cover reset mid-operation: rst=0 asserted between request and grant edge -> g_va_o stays 000, reserved_o=000000 asynchronously.
REQ-038 SHALL cover the invalid VNET id: vnet field=11 -> never granted, no pointer change.

Source files
------------

// File: rtl/vc_allocator_rr.sv
// Virtual-channel allocator: one requester arbiter and one VC arbiter per VNET.
// Each grant is registered, and the granted VC stays reserved until it is released.

// Arbiter for one VNET. It picks one requester and one eligible VC.
module vc_alloc_vnet #(
  parameter int NR   = 3,
  parameter int NC   = 2,
  parameter int MODE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NR-1:0] req,
  input  logic [NC-1:0] elig,
  output logic [NR-1:0] req_gnt,
  output logic [NC-1:0] vc_gnt
);
  localparam int RW = (NR > 1) ? $clog2(NR) : 1;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;

  logic [RW-1:0] rptr;
  logic [CW-1:0] cptr;
  int            rbase, cbase, rwin, cwin;
  logic          rfound, cfound, grant;

  // Rotating search: indices at or above the pointer first, then the wrapped part.
  always_comb begin
    rbase  = (MODE == 1) ? int'(rptr) : 0;
    cbase  = (MODE == 1) ? int'(cptr) : 0;
    rwin   = 0;
    cwin   = 0;
    rfound = 1'b0;
    cfound = 1'b0;
    for (int j = 0; j < NR; j++)
      if (!rfound && req[j] && j >= rbase) begin rfound = 1'b1; rwin = j; end
    for (int j = 0; j < NR; j++)
      if (!rfound && req[j] && j < rbase) begin rfound = 1'b1; rwin = j; end
    for (int j = 0; j < NC; j++)
      if (!cfound && elig[j] && j >= cbase) begin cfound = 1'b1; cwin = j; end
    for (int j = 0; j < NC; j++)
      if (!cfound && elig[j] && j < cbase) begin cfound = 1'b1; cwin = j; end
    grant = rfound && cfound;
    for (int j = 0; j < NR; j++) req_gnt[j] = grant && (rwin == j);
    for (int j = 0; j < NC; j++) vc_gnt[j]  = grant && (cwin == j);
  end

  // Both pointers move past the winner, and they move only when a grant is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr <= '0;
      cptr <= '0;
    end else if (MODE == 1 && grant) begin
      rptr <= RW'((rwin == NR-1) ? 0 : rwin + 1);
      cptr <= CW'((cwin == NC-1) ? 0 : cwin + 1);
    end
  end
endmodule

module vc_allocator_rr #(
  parameter int N_OF_REQUEST   = 3,
  parameter int N_OF_VN        = 3,
  parameter int N_OF_VC        = 2,
  parameter int N_BITS_VNET_ID = (N_OF_VN > 1) ? $clog2(N_OF_VN) : 1,
  parameter int ALLOC_MODE     = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_OF_REQUEST-1:0]                   r_va_i,
  input  logic [N_OF_REQUEST*N_BITS_VNET_ID-1:0]    vnet_of_the_request_i,
  input  logic [N_OF_VC*N_OF_VN-1:0]                free_signal_i,
  input  logic [N_OF_VC*N_OF_VN-1:0]                fifo_pointer_state_i,
  input  logic [N_OF_VC*N_OF_VN-1:0]                release_vc_i,
  output logic [N_OF_REQUEST-1:0]                   g_va_o,
  output logic [N_OF_REQUEST*N_OF_VC*N_OF_VN-1:0]   g_vc_id_o,
  output logic [N_OF_VC*N_OF_VN-1:0]                reserved_o
);
  localparam int NVC = N_OF_VC * N_OF_VN;

  logic [NVC-1:0]                                reserved, eligible;
  logic [N_OF_REQUEST-1:0][N_BITS_VNET_ID-1:0]   vnet_id;
  logic [N_OF_VN-1:0][N_OF_REQUEST-1:0]          vn_req, vn_rgnt;
  logic [N_OF_VN-1:0][N_OF_VC-1:0]               vn_elig, vn_vgnt;
  logic [N_OF_REQUEST-1:0]                       gnt_nxt;
  logic [N_OF_REQUEST-1:0][NVC-1:0]              gid_nxt, gid_q;

  assign vnet_id  = vnet_of_the_request_i;
  assign eligible = free_signal_i & fifo_pointer_state_i & ~reserved;
  assign vn_elig  = eligible;

  // Send each active requester to its VNET. A requester that is being granted this
  // cycle is masked. An out-of-range id matches no VNET, so it is never granted.
  always_comb begin
    vn_req = '0;
    for (int k = 0; k < N_OF_REQUEST; k++)
      for (int v = 0; v < N_OF_VN; v++)
        if (r_va_i[k] && !g_va_o[k] && int'(vnet_id[k]) == v) vn_req[v][k] = 1'b1;
  end

  for (genvar v = 0; v < N_OF_VN; v++) begin : g_vnet
    vc_alloc_vnet #(.NR(N_OF_REQUEST), .NC(N_OF_VC), .MODE(ALLOC_MODE)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (vn_req[v]),
      .elig    (vn_elig[v]),
      .req_gnt (vn_rgnt[v]),
      .vc_gnt  (vn_vgnt[v])
    );
  end

  // Collect the per-VNET winners into per-requester grant and one-hot VC fields.
  always_comb begin
    gnt_nxt = '0;
    gid_nxt = '0;
    for (int v = 0; v < N_OF_VN; v++)
      for (int k = 0; k < N_OF_REQUEST; k++)
        if (vn_rgnt[v][k]) begin
          gnt_nxt[k]                       = 1'b1;
          gid_nxt[k][v*N_OF_VC +: N_OF_VC] = vn_vgnt[v];
        end
  end

  // Grant registers and the reservation mask. A granted VC was unreserved before
  // the edge, so a release on that VC cannot cancel the new reservation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_va_o   <= '0;
      gid_q    <= '0;
      reserved <= '0;
    end else begin
      g_va_o   <= gnt_nxt;
      gid_q    <= gid_nxt;
      reserved <= (reserved & ~release_vc_i) | vn_vgnt;
    end
  end

  assign g_vc_id_o  = gid_q;
  assign reserved_o = reserved;
endmodule

// File: tb/tb_vc_allocator_rr.sv
// Scoreboard bench for vc_allocator_rr (3 requesters, 3 VNETs, 2 VCs, round-robin).
module tb_vc_allocator_rr;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  r_va_i = '0;
  logic [5:0]  vnet_of_the_request_i = '0;
  logic [5:0]  free_signal_i = '0, fifo_pointer_state_i = '0, release_vc_i = '0;
  logic [2:0]  g_va_o;
  logic [17:0] g_vc_id_o;
  logic [5:0]  reserved_o;

  typedef struct {
    logic [2:0]  g;
    logic [17:0] id;
    logic [5:0]  res;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step  = 0;

  vc_allocator_rr #(.N_OF_REQUEST(3), .N_OF_VN(3), .N_OF_VC(2), .ALLOC_MODE(1)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .r_va_i                (r_va_i),
    .vnet_of_the_request_i (vnet_of_the_request_i),
    .free_signal_i         (free_signal_i),
    .fifo_pointer_state_i  (fifo_pointer_state_i),
    .release_vc_i          (release_vc_i),
    .g_va_o                (g_va_o),
    .g_vc_id_o             (g_vc_id_o),
    .reserved_o            (reserved_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  // One cycle of stimulus; the expected registered outputs after the next edge are queued.
  task automatic cyc(input logic [2:0] r, input logic [5:0] vn, input logic [5:0] fr,
                     input logic [5:0] fi, input logic [5:0] rel,
                     input logic [2:0] eg, input logic [17:0] eid, input logic [5:0] er);
    exp_t e;
    @(negedge clk);
    r_va_i = r; vnet_of_the_request_i = vn; free_signal_i = fr;
    fifo_pointer_state_i = fi; release_vc_i = rel;
    step++;
    e.g = eg; e.id = eid; e.res = er; e.tag = step;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    r_va_i = '0; vnet_of_the_request_i = '0; free_signal_i = '0;
    fifo_pointer_state_i = '0; release_vc_i = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: every output sample that has a queued expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("g_va",     e.tag, 32'(g_va_o),     32'(e.g));
        chk("g_vc_id",  e.tag, 32'(g_vc_id_o),  32'(e.id));
        chk("reserved", e.tag, 32'(reserved_o), 32'(e.res));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_g_va", 0, 32'(g_va_o), 32'h0);
    chk("rst_id",   0, 32'(g_vc_id_o), 32'h0);
    chk("rst_res",  0, 32'(reserved_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Basic grant. VNET2 has no eligible VC, so req2 gets nothing.
    cyc(3'b101, 6'b100101, 6'b011111, 6'b101101, 6'b0, 3'b001, 18'h00004, 6'b000100);
    cyc(3'b000, 6'b100101, 6'b011111, 6'b101101, 6'b0, 3'b000, 18'h00000, 6'b000100);
    do_reset();

    // Round-robin on VNET0
    cyc(3'b011, 6'b0, 6'h3F, 6'h3F, 6'b0,      3'b001, 18'h00001, 6'b000001);
    cyc(3'b011, 6'b0, 6'h3F, 6'h3F, 6'b0,      3'b010, 18'h00080, 6'b000011);
    cyc(3'b000, 6'b0, 6'h3F, 6'h3F, 6'b000011, 3'b000, 18'h00000, 6'b000000);
    cyc(3'b111, 6'b0, 6'h3F, 6'h3F, 6'b0,      3'b100, 18'h01000, 6'b000001);
    cyc(3'b011, 6'b0, 6'h3F, 6'h3F, 6'b0,      3'b001, 18'h00002, 6'b000011);
    cyc(3'b010, 6'b0, 6'h3F, 6'h3F, 6'b0,      3'b000, 18'h00000, 6'b000011);
    cyc(3'b010, 6'b0, 6'h3F, 6'h3F, 6'b000001, 3'b000, 18'h00000, 6'b000010);
    cyc(3'b010, 6'b0, 6'h3F, 6'h3F, 6'b0,      3'b010, 18'h00040, 6'b000011);
    cyc(3'b000, 6'b0, 6'h3F, 6'h3F, 6'b0,      3'b000, 18'h00000, 6'b000011);
    do_reset();

    // VNET1 exhaustion, then a release in the same cycle as a VNET1 request
    cyc(3'b011, 6'b000101, 6'h3F, 6'h3F, 6'b0,      3'b001, 18'h00004, 6'b000100);
    cyc(3'b011, 6'b000101, 6'h3F, 6'h3F, 6'b0,      3'b010, 18'h00200, 6'b001100);
    cyc(3'b100, 6'b010101, 6'h3F, 6'h3F, 6'b0,      3'b000, 18'h00000, 6'b001100);
    cyc(3'b100, 6'b010101, 6'h3F, 6'h3F, 6'b0,      3'b000, 18'h00000, 6'b001100);
    cyc(3'b100, 6'b010101, 6'h3F, 6'h3F, 6'b000100, 3'b000, 18'h00000, 6'b001000);
    cyc(3'b100, 6'b010101, 6'h3F, 6'h3F, 6'b0,      3'b100, 18'h04000, 6'b001100);
    cyc(3'b000, 6'b010101, 6'h3F, 6'h3F, 6'b0,      3'b000, 18'h00000, 6'b001100);

    // Invalid VNET id 3 on req0 is never granted; req1 on VNET2 still is
    cyc(3'b001, 6'b010111, 6'h3F, 6'h3F, 6'b0, 3'b000, 18'h00000, 6'b001100);
    cyc(3'b001, 6'b010111, 6'h3F, 6'h3F, 6'b0, 3'b000, 18'h00000, 6'b001100);
    cyc(3'b011, 6'b011011, 6'h3F, 6'h3F, 6'b0, 3'b010, 18'h00400, 6'b011100);
    cyc(3'b001, 6'b011011, 6'h3F, 6'h3F, 6'b0, 3'b000, 18'h00000, 6'b011100);

    // Reset asserted between the request and the grant edge
    @(negedge clk);
    r_va_i = 3'b001; vnet_of_the_request_i = '0;
    free_signal_i = 6'h3F; fifo_pointer_state_i = 6'h3F; release_vc_i = '0;
    #2 rst = 1'b0;
    #1;
    chk("async_g_va", 100, 32'(g_va_o), 32'h0);
    chk("async_id",   100, 32'(g_vc_id_o), 32'h0);
    chk("async_res",  100, 32'(reserved_o), 32'h0);
    @(posedge clk);
    #1;
    chk("held_g_va", 101, 32'(g_va_o), 32'h0);
    chk("held_res",  101, 32'(reserved_o), 32'h0);
    @(negedge clk);
    r_va_i = '0;
    rst = 1'b1;

    // Pointers restart at 0 after reset: the VNET1 grant goes to VC0 (bit 2)
    cyc(3'b001, 6'b000001, 6'h3F, 6'h3F, 6'b0, 3'b001, 18'h00004, 6'b000100);
    cyc(3'b000, 6'b000001, 6'h3F, 6'h3F, 6'b0, 3'b000, 18'h00000, 6'b000100);

    @(posedge clk);
    #2;
    chk("sb_drained", 200, 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
